// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a req/ack
// memory port and offers it to decode on a valid/ready port; execute may redirect the PC.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [5:0]       inst_opcode,
    output logic [31:0]      inst_pc,
    output logic             align_err,
    output logic [CNT_W-1:0] fetch_count,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [31:0]      pc_q, pc_nxt;
    logic [31:0]      inst_q, inst_nxt;
    logic [31:0]      inst_pc_q, inst_pc_nxt;
    logic             align_q, align_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             accept;

    // Decode handshake: an instruction transfers on any rising edge where inst_valid
    // and inst_ready are both high; inst/inst_pc stay frozen while inst_valid waits.
    always_comb begin
        state_nxt   = state_q;
        pc_nxt      = pc_q;
        inst_nxt    = inst_q;
        inst_pc_nxt = inst_pc_q;
        count_nxt   = count_q;
        accept      = (state_q == HOLD) && inst_ready;
        align_nxt   = redirect_valid && (redirect_pc[1:0] != 2'b00);

        case (state_q)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_ack) begin
                    state_nxt   = HOLD;
                    inst_nxt    = imem_rdata;
                    inst_pc_nxt = pc_q;
                    pc_nxt      = pc_q + 32'd4;
                end
            end
            HOLD: begin
                if (inst_ready) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase

        // A redirect discards any coincident memory response but not a decode transfer.
        if (redirect_valid) begin
            state_nxt   = REQ;
            pc_nxt      = {redirect_pc[31:2], 2'b00};
            inst_nxt    = inst_q;
            inst_pc_nxt = inst_pc_q;
        end

        if (accept && (count_q != {CNT_W{1'b1}})) begin
            count_nxt = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            align_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_nxt;
            pc_q      <= pc_nxt;
            inst_q    <= inst_nxt;
            inst_pc_q <= inst_pc_nxt;
            align_q   <= align_nxt;
            count_q   <= count_nxt;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign inst_valid  = (state_q == HOLD);
    assign inst        = inst_q;
    assign inst_opcode = inst_q[31:26];
    assign inst_pc     = inst_pc_q;
    assign align_err   = align_q;
    assign fetch_count = count_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic, checked against a
// transaction-level model of the fetch stage; a second instance checks counter saturation.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [5:0]  inst_opcode;
    logic [31:0] inst_pc;
    logic        align_err;
    logic [15:0] fetch_count;
    logic [1:0]  fsm_state;

    logic        req2, ack2, valid2, align2;
    logic [31:0] addr2, inst2, pc2;
    logic [5:0]  op2;
    logic [1:0]  fc2, st2;

    int tests = 0;
    int fails = 0;

    // Model of the stage, kept as "what has been fetched and not yet handed over"
    bit          m_fresh;      // first cycle after reset, no request yet
    bit          m_have;       // an instruction is waiting for decode
    logic [31:0] m_pc, m_inst, m_inst_pc;
    logic        m_align;
    int          m_count;
    localparam int CNT_MAX = 65535;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_opcode(inst_opcode),
        .inst_pc(inst_pc), .align_err(align_err), .fetch_count(fetch_count), .fsm_state(fsm_state)
    );

    assign ack2 = req2;

    ifetch_unit #(.RESET_PC(32'h0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(32'h1234_5678),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(valid2), .inst_ready(1'b1), .inst(inst2), .inst_opcode(op2),
        .inst_pc(pc2), .align_err(align2), .fetch_count(fc2), .fsm_state(st2)
    );

    function automatic bit exp_req();
        return !m_fresh && !m_have;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req()});
        if (exp_req()) chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_have});
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_inst_pc);
        chk("inst_opcode", {26'd0, inst_opcode}, {26'd0, m_inst[31:26]});
        chk("align_err", {31'd0, align_err}, {31'd0, m_align});
        chk("fetch_count", {16'd0, fetch_count}, m_count);
    endtask

    // Advance the model by one edge using the inputs currently applied, then let the
    // DUT take the same edge and compare on the following falling edge.
    task automatic tick();
        bit acc;
        acc = m_have && inst_ready;
        if (!rst_n) begin
            m_fresh = 1; m_have = 0; m_pc = 32'h0; m_inst = 32'h0;
            m_inst_pc = 32'h0; m_align = 0; m_count = 0;
        end else begin
            if (acc && m_count < CNT_MAX) m_count++;
            m_align = redirect_valid && (redirect_pc % 4 != 0);
            if (redirect_valid) begin
                m_pc = redirect_pc & ~32'd3; m_have = 0; m_fresh = 0;
            end else if (m_fresh) begin
                m_fresh = 0;
            end else if (!m_have) begin
                if (imem_ack) begin
                    m_inst = imem_rdata; m_inst_pc = m_pc; m_pc = m_pc + 32'd4; m_have = 1;
                end
            end else if (inst_ready) begin
                m_have = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic fetch_one(input int delay, input int hold, input logic [31:0] data, input bit use_data);
        redirect_valid = 0;
        imem_ack = 0;
        if (m_fresh) tick();
        for (int i = 0; i < delay; i++) begin
            imem_ack = 0;
            tick();
            chk("slow_req", {31'd0, imem_req}, 32'd1);
        end
        imem_ack = exp_req();
        imem_rdata = use_data ? data : (m_pc ^ 32'hA5A5_0000);
        tick();
        imem_ack = 0;
        imem_rdata = $urandom;
        for (int i = 0; i < hold; i++) begin
            inst_ready = 0;
            tick();
            if (use_data) chk("bp_opcode", {26'd0, inst_opcode}, {26'd0, data[31:26]});
        end
        inst_ready = 1;
        tick();
        inst_ready = 0;
    endtask

    task automatic redirect_to(input logic [31:0] addr, input bit with_ack);
        redirect_valid = 1;
        redirect_pc = addr;
        imem_ack = with_ack && exp_req();
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        redirect_valid = 0;
        imem_ack = 0;
    endtask

    initial begin
        rst_n = 0; imem_ack = 0; imem_rdata = 32'h0; redirect_valid = 0;
        redirect_pc = 32'h0; inst_ready = 0;

        // reset held for three edges
        for (int i = 0; i < 3; i++) tick();
        chk("sat_reset", {30'd0, fc2}, 32'd0);
        rst_n = 1;

        // first fetches, memory answering one cycle after the request
        inst_ready = 1;
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) fetch_one(1, 0, 32'h0, 0);
        chk("count3", {16'd0, fetch_count}, 32'd3);
        chk("third_pc", inst_pc, 32'h8);
        chk("third_inst", inst, 32'hA5A5_0008);

        // decode backpressure, then a slow memory
        fetch_one(0, 5, 32'h2001_0005, 1);
        chk("bp_count", {16'd0, fetch_count}, 32'd4);
        fetch_one(4, 0, 32'h0, 0);

        // redirect that collides with a memory response
        redirect_to(32'h10, 0);
        redirect_to(32'h100, 1);
        chk("redir_valid", {31'd0, inst_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        fetch_one(0, 0, 32'h0, 0);
        chk("redir_inst_pc", inst_pc, 32'h100);

        // misaligned redirect
        redirect_to(32'h0000_0203, 0);
        chk("mis_addr", imem_addr, 32'h200);
        chk("align_pulse", {31'd0, align_err}, 32'd1);
        tick();
        chk("align_clear", {31'd0, align_err}, 32'd0);

        // PC wrap at the top of the address space
        redirect_to(32'hFFFF_FFFC, 0);
        fetch_one(0, 0, 32'h0, 0);
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // reset while a request is outstanding
        tick();
        rst_n = 0;
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_count", {16'd0, fetch_count}, 32'd0);
        rst_n = 1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            imem_ack = exp_req() && ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            tick();
        end

        chk("sat_count", {30'd0, fc2}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
